// File: rtl/ddr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ddr_pkg
// Brief    : Shared grade encoding, lane geometry defaults and speed constants.
// Revision : 1.0 - initial release
// ============================================================================
package ddr_pkg;

    localparam int DEFAULT_ROWS    = 16;
    localparam int DEFAULT_HIT_ROW = 14;
    localparam int DEFAULT_WINDOW  = 1;

    localparam int SPEED_W     = 4;
    localparam int SPEED_UNITS = 16;

    typedef enum logic [1:0] {
        GRADE_NONE    = 2'd0,
        GRADE_GOOD    = 2'd1,
        GRADE_PERFECT = 2'd2,
        GRADE_EMPTY   = 2'd3
    } grade_t;

    function automatic grade_t grade_of(input logic press, input logic found, input logic at_hit);
        if (!press)      return GRADE_NONE;
        else if (!found) return GRADE_EMPTY;
        else if (at_hit) return GRADE_PERFECT;
        else             return GRADE_GOOD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_step_timer.sv
`default_nettype none
// ============================================================================
// Module   : lane_step_timer
// Brief    : Emits a step pulse on the last cycle of each PRESCALE*(16-speed) period.
// Revision : 1.0 - initial release
// ============================================================================
module lane_step_timer
    import ddr_pkg::*;
#(
    parameter int PRESCALE = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SPEED_W-1:0] light_speed,
    input  logic               pause,
    output logic               step
);

    localparam int CW = $clog2(PRESCALE * SPEED_UNITS + 1);
    localparam logic [CW-1:0]      c_prescale = CW'(PRESCALE);
    localparam logic [SPEED_W:0]   c_units    = (SPEED_W + 1)'(SPEED_UNITS);

    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    r_last;
    logic [CW-1:0]    w_last;
    logic [SPEED_W:0] w_units;

    // Speed is only looked at when the count is zero, so a period in flight keeps its length.
    always_comb begin
        w_units = c_units - {1'b0, light_speed};
        w_last  = (r_cnt == '0) ? (c_prescale * CW'(w_units)) - CW'(1) : r_last;
        step    = !pause && (r_cnt == w_last);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_last <= '0;
        end else if (!pause) begin
            r_last <= w_last;
            r_cnt  <= step ? '0 : r_cnt + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/note_lane.sv
`default_nettype none
// ============================================================================
// Module   : note_lane
// Brief    : One rhythm-game lane: falling notes, press grading and miss detection.
// Revision : 1.0 - initial release
// ============================================================================
module note_lane
    import ddr_pkg::*;
#(
    parameter int ROWS     = DEFAULT_ROWS,
    parameter int HIT_ROW  = DEFAULT_HIT_ROW,
    parameter int WINDOW   = DEFAULT_WINDOW,
    parameter int PRESCALE = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               spawn,
    input  logic               user_button,
    input  logic [SPEED_W-1:0] light_speed,
    input  logic               pause,
    output logic [ROWS-1:0]    lane,
    output logic               hit_perfect,
    output logic               hit_good,
    output logic               light_lost,
    output logic               empty_press
);

    localparam int RW = $clog2(ROWS);
    localparam logic [RW-1:0] c_hit = RW'(HIT_ROW);

    logic [ROWS-1:0] r_lane;
    logic            r_btn_prev;
    logic            r_lost;
    grade_t          r_grade;

    logic            w_step;
    logic            w_press;
    logic            w_found;
    logic [RW-1:0]   w_sel;
    logic [ROWS-1:0] w_clear;
    logic [ROWS-1:0] w_kept;
    logic [ROWS-1:0] w_next;
    logic            w_lost;
    grade_t          w_grade;

    lane_step_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .light_speed (light_speed),
        .pause       (pause),
        .step        (w_step)
    );

    always_comb begin
        w_press = user_button & ~r_btn_prev;
        w_found = 1'b0;
        w_sel   = '0;
        // Scan outermost rows first so nearer rows override; lower row checked last wins a tie.
        for (int d = WINDOW; d >= 1; d--) begin
            if (r_lane[RW'(HIT_ROW + d)]) begin
                w_found = 1'b1;
                w_sel   = RW'(HIT_ROW + d);
            end
            if (r_lane[RW'(HIT_ROW - d)]) begin
                w_found = 1'b1;
                w_sel   = RW'(HIT_ROW - d);
            end
        end
        if (r_lane[c_hit]) begin
            w_found = 1'b1;
            w_sel   = c_hit;
        end

        w_clear = '0;
        if (w_press && w_found) w_clear[w_sel] = 1'b1;
        w_kept  = r_lane & ~w_clear;

        w_next = w_kept;
        w_lost = 1'b0;
        if (w_step) begin
            w_lost = w_kept[ROWS-1];
            w_next = w_kept << 1;
        end
        if (spawn && !pause) w_next[0] = 1'b1;

        w_grade = grade_of(w_press, w_found, w_sel == c_hit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lane     <= '0;
            r_btn_prev <= 1'b0;
            r_lost     <= 1'b0;
            r_grade    <= GRADE_NONE;
        end else begin
            r_lane     <= w_next;
            r_btn_prev <= user_button;
            r_lost     <= w_lost;
            r_grade    <= w_grade;
        end
    end

    assign lane        = r_lane;
    assign light_lost  = r_lost;
    assign hit_perfect = (r_grade == GRADE_PERFECT);
    assign hit_good    = (r_grade == GRADE_GOOD);
    assign empty_press = (r_grade == GRADE_EMPTY);

endmodule
`default_nettype wire

// File: doc/note_lane.md
NOTE_LANE -- requirements
Module: note_lane

Interface
REQ-001 Parameter ROWS, default 16: number of rows in the lane, minimum 4.
REQ-002 Parameter HIT_ROW, default 14: target row index; SHALL satisfy WINDOW <= HIT_ROW <= ROWS-1-WINDOW.
REQ-003 Parameter WINDOW, default 1: rows either side of HIT_ROW that accept a press.
REQ-004 Parameter PRESCALE, default 1000: clock cycles per speed unit.
REQ-005 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 spawn  in  1  request a note at row 0.
REQ-008 user_button  in  1  player button level, already synchronised.
REQ-009 light_speed  in  4  step rate; 15 is fastest.
REQ-010 pause  in  1  freezes note motion while high.
REQ-011 lane  out  ROWS  occupancy vector; bit r high = note at row r; registered.
REQ-012 hit_perfect  out  1  one-cycle pulse: press accepted with note at HIT_ROW.
REQ-013 hit_good  out  1  one-cycle pulse: press accepted, note in window but not at HIT_ROW.
REQ-014 light_lost  out  1  one-cycle pulse: note stepped out past row ROWS-1.
REQ-015 empty_press  out  1  one-cycle pulse: press with no note in window.

Function
REQ-016 Step period SHALL be PRESCALE*(16-light_speed) cycles; a step pulse SHALL fire on the last cycle of each period.
REQ-017 light_speed SHALL be sampled only when a new period starts; mid-period changes SHALL NOT alter the current period.
REQ-018 On a step, every note SHALL move from row r to row r+1; a note at ROWS-1 SHALL be removed and light_lost asserted the next cycle.
REQ-019 While pause is high: the step counter SHALL hold, no step SHALL occur, spawn SHALL be ignored, presses SHALL still be evaluated.
REQ-020 spawn high SHALL set lane[0] the next cycle; when spawn and a step coincide, the shift SHALL apply first, then lane[0] SHALL be set.
REQ-021 Press event = user_button rising edge (registered previous value); held button SHALL NOT retrigger.
REQ-022 On a press, the note in rows HIT_ROW-WINDOW..HIT_ROW+WINDOW nearest HIT_ROW SHALL be cleared; on a tie, the lower row wins.
REQ-023 Press evaluation SHALL use the pre-step lane; a cleared note SHALL NOT also shift or produce light_lost.
REQ-024 Only one note SHALL be cleared per press.
REQ-025 Grading: cleared note at HIT_ROW -> hit_perfect; cleared note elsewhere in window -> hit_good; no note in window -> empty_press.
REQ-026 hit_perfect, hit_good and empty_press SHALL be mutually exclusive, and each SHALL assert exactly one cycle after the press edge.
REQ-027 light_lost SHALL be able to coincide with any grading pulse.

Reset
REQ-028 During reset: lane = 0; all pulses = 0; step counter = 0; previous button = 0; light_speed resampled on the first post-reset cycle.
REQ-029 Reset mid-operation SHALL discard all notes without generating light_lost.

Structure
REQ-030 Shared package ddr_pkg SHALL hold the grade enum (GRADE_NONE, GRADE_GOOD, GRADE_PERFECT, GRADE_EMPTY) and the default ROWS, HIT_ROW and WINDOW constants.
REQ-031 Step timing SHALL be a sub-module lane_step_timer (inputs clk, reset, light_speed, pause; output step); lane shift and grading SHALL stay in note_lane.

Verification (PRESCALE=1, ROWS=16, HIT_ROW=14, WINDOW=1)
REQ-032 Reset, then press with lane empty -> empty_press=1 for exactly 1 cycle; lane stays 0.
REQ-033 light_speed=15, spawn once -> note advances one row per cycle; light_lost pulses once, 16 steps after the spawn.
REQ-034 Note at row 14, press -> hit_perfect=1 next cycle, lane bit 14 cleared, no light_lost afterwards.
REQ-035 Notes at rows 13 and 15, press -> row 13 cleared, hit_good=1; second press -> row 15 cleared (or its shifted successor if still in window), otherwise empty_press.
REQ-036 light_speed=14, pause high for 10 cycles mid-flight -> lane frozen and spawn ignored; resume -> period continues from the held count.
REQ-037 Button held high for 20 cycles over a note in window -> exactly one grading pulse; reset asserted with notes present -> lane=0 and no light_lost.
